// File: rtl/spi_pkg.sv
// Shared definitions for the SPI receive path: default word/synchronizer sizes
// and the receiver FSM state encoding.
package spi_pkg;

    localparam int SPI_WORD_W      = 16;
    localparam int SPI_SYNC_STAGES = 2;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } spi_state_e;

endpackage

// File: rtl/spi_sync.sv
// N-stage flop synchronizer for one asynchronous input, with a selectable
// reset level so idle-high lines (cs_n) come out of reset inactive.
module spi_sync #(
    parameter int   N       = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [N-1:0] sync_r;

    // shift the asynchronous input through the flop chain
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_r <= {N{RST_VAL}};
        end else begin
            sync_r <= {sync_r[N-2:0], d};
        end
    end

    assign q = sync_r[N-1];

endmodule

// File: rtl/spi_rx_deser.sv
// SPI mode-0 receiver: oversamples sclk/cs_n/mosi in the clk domain, assembles
// WIDTH-bit words and offers them on a valid/ready port with sticky overflow.
module spi_rx_deser
    import spi_pkg::*;
#(
    parameter int WIDTH       = SPI_WORD_W,
    parameter bit MSB_FIRST   = 1'b1,
    parameter int SYNC_STAGES = SPI_SYNC_STAGES
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sclk,
    input  logic             cs_n,
    input  logic             mosi,
    output logic [WIDTH-1:0] rx_data,
    output logic             rx_valid,
    input  logic             rx_ready,
    output logic             overflow,
    input  logic             ovf_clr,
    output logic             busy
);

    localparam int               CNT_W    = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic             sclk_s;
    logic             cs_n_s;
    logic             mosi_s;
    logic             sclk_dly_r;
    logic             rise_s;
    spi_state_e       state_r;
    spi_state_e       state_nxt_s;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_nxt_s;
    logic [WIDTH-1:0] shift_r;
    logic [WIDTH-1:0] shift_nxt_s;
    logic [WIDTH-1:0] shifted_s;
    logic             done_r;
    logic             done_nxt_s;
    logic             load_s;
    logic             drop_s;
    logic [WIDTH-1:0] rx_data_r;
    logic             rx_valid_r;
    logic             overflow_r;
    logic             busy_r;

    spi_sync #(.N(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
        .clk (clk), .rst (rst), .d (sclk), .q (sclk_s)
    );
    spi_sync #(.N(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
        .clk (clk), .rst (rst), .d (mosi), .q (mosi_s)
    );
    spi_sync #(.N(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs_n (
        .clk (clk), .rst (rst), .d (cs_n), .q (cs_n_s)
    );

    assign rise_s = sclk_s & ~sclk_dly_r;

    // shift direction: MSB_FIRST fills from the LSB end upwards
    always_comb begin
        shifted_s = shift_r;
        if (MSB_FIRST) begin
            shifted_s = {shift_r[WIDTH-2:0], mosi_s};
        end else begin
            shifted_s = {mosi_s, shift_r[WIDTH-1:1]};
        end
    end

    // next-state, bit counter and shift register update
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        shift_nxt_s = shift_r;
        done_nxt_s  = 1'b0;
        case (state_r)
            IDLE: begin
                cnt_nxt_s   = {CNT_W{1'b0}};
                shift_nxt_s = {WIDTH{1'b0}};
                if (!cs_n_s) begin
                    state_nxt_s = SHIFT;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            SHIFT: begin
                if (rise_s) begin
                    shift_nxt_s = shifted_s;
                    if (cnt_r == LAST_CNT) begin
                        cnt_nxt_s  = {CNT_W{1'b0}};
                        done_nxt_s = 1'b1;
                    end else begin
                        cnt_nxt_s = cnt_r + CNT_ONE;
                    end
                end else begin
                    cnt_nxt_s = cnt_r;
                end
                // a word completed on this same rise is still delivered;
                // the shift register is only cleared once back in IDLE
                if (cs_n_s) begin
                    state_nxt_s = IDLE;
                    cnt_nxt_s   = {CNT_W{1'b0}};
                end else begin
                    state_nxt_s = SHIFT;
                end
            end
            default: begin
                state_nxt_s = IDLE;
                cnt_nxt_s   = {CNT_W{1'b0}};
                shift_nxt_s = {WIDTH{1'b0}};
            end
        endcase
    end

    // receiver state registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r    <= IDLE;
            cnt_r      <= {CNT_W{1'b0}};
            shift_r    <= {WIDTH{1'b0}};
            done_r     <= 1'b0;
            sclk_dly_r <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            cnt_r      <= cnt_nxt_s;
            shift_r    <= shift_nxt_s;
            done_r     <= done_nxt_s;
            sclk_dly_r <= sclk_s;
        end
    end

    assign load_s = done_r & (~rx_valid_r | rx_ready);
    assign drop_s = done_r & rx_valid_r & ~rx_ready;

    // output word, handshake, sticky overflow and busy flag
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_data_r  <= {WIDTH{1'b0}};
            rx_valid_r <= 1'b0;
            overflow_r <= 1'b0;
            busy_r     <= 1'b0;
        end else begin
            if (load_s) begin
                rx_data_r  <= shift_r;
                rx_valid_r <= 1'b1;
            end else if (rx_ready) begin
                rx_valid_r <= 1'b0;
            end else begin
                rx_valid_r <= rx_valid_r;
            end
            if (drop_s) begin
                overflow_r <= 1'b1;
            end else if (ovf_clr) begin
                overflow_r <= 1'b0;
            end else begin
                overflow_r <= overflow_r;
            end
            busy_r <= (state_nxt_s == SHIFT);
        end
    end

    assign rx_data  = rx_data_r;
    assign rx_valid = rx_valid_r;
    assign overflow = overflow_r;
    assign busy     = busy_r;

endmodule

// File: tb/tb_spi_rx_deser.sv
// Directed bench for spi_rx_deser: one MSB-first and one LSB-first instance
// share the SPI pins; scenarios drive frames and check results inline.
module tb_spi_rx_deser;

    localparam int W  = 16;
    localparam int PH = 6;
    localparam int SS = 2;

    logic         clk       = 1'b0;
    logic         rst       = 1'b0;
    logic         sclk      = 1'b0;
    logic         cs_n      = 1'b1;
    logic         mosi      = 1'b0;
    logic         rx_ready  = 1'b0;
    logic         ovf_clr   = 1'b0;
    logic         rx_ready2 = 1'b1;
    logic [W-1:0] rx_data;
    logic [W-1:0] rx_data2;
    logic         rx_valid;
    logic         rx_valid2;
    logic         overflow;
    logic         overflow2;
    logic         busy;
    logic         busy2;
    int           total = 0;
    int           bad   = 0;

    spi_rx_deser #(.WIDTH(W), .MSB_FIRST(1'b1), .SYNC_STAGES(SS)) dut (
        .clk(clk), .rst(rst), .sclk(sclk), .cs_n(cs_n), .mosi(mosi),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .overflow(overflow), .ovf_clr(ovf_clr), .busy(busy)
    );

    spi_rx_deser #(.WIDTH(W), .MSB_FIRST(1'b0), .SYNC_STAGES(SS)) dut_lsb (
        .clk(clk), .rst(rst), .sclk(sclk), .cs_n(cs_n), .mosi(mosi),
        .rx_data(rx_data2), .rx_valid(rx_valid2), .rx_ready(rx_ready2),
        .overflow(overflow2), .ovf_clr(ovf_clr), .busy(busy2)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // shift the top n bits of w onto the wire, MSB first, ending with sclk low
    task automatic shift_bits(input logic [W-1:0] w, input int n);
        for (int i = 0; i < n; i++) begin
            mosi = w[W-1-i];
            tick(PH);
            sclk = 1'b1;
            tick(PH);
            sclk = 1'b0;
        end
    endtask

    task automatic frame(input logic [W-1:0] w);
        cs_n = 1'b0;
        tick(PH);
        shift_bits(w, W);
        tick(PH);
        cs_n = 1'b1;
        tick(PH);
    endtask

    task automatic test_reset();
        rst = 1'b0;
        tick(3);
        total++; if (rx_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", rx_valid); end
        total++; if (rx_data !== 16'h0000) begin bad++; $display("FAIL reset_data got=%h exp=0000", rx_data); end
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL reset_ovf got=%b exp=0", overflow); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
        rst = 1'b1;
        tick(PH);
    endtask

    task automatic test_basic();
        rx_ready = 1'b1;
        cs_n = 1'b0;
        tick(PH);
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL basic_busy_on got=%b exp=1", busy); end
        shift_bits(16'hA5C3, W - 1);
        mosi = 1'b1;
        tick(PH);
        sclk = 1'b1;
        tick(SS + 1);
        total++; if (rx_valid !== 1'b0) begin bad++; $display("FAIL basic_early_valid got=%b exp=0", rx_valid); end
        tick(1);
        total++; if (rx_valid !== 1'b1) begin bad++; $display("FAIL basic_valid got=%b exp=1", rx_valid); end
        total++; if (rx_data !== 16'hA5C3) begin bad++; $display("FAIL basic_data got=%h exp=a5c3", rx_data); end
        tick(1);
        total++; if (rx_valid !== 1'b0) begin bad++; $display("FAIL basic_pulse got=%b exp=0", rx_valid); end
        tick(PH);
        sclk = 1'b0;
        tick(PH);
        cs_n = 1'b1;
        tick(PH);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL basic_busy_off got=%b exp=0", busy); end
        total++; if (rx_valid !== 1'b0) begin bad++; $display("FAIL basic_no_repeat got=%b exp=0", rx_valid); end
    endtask

    task automatic test_bit_order();
        rx_ready = 1'b1;
        frame(16'h0001);
        total++; if (rx_data2 !== 16'h8000) begin bad++; $display("FAIL order_lsb_data got=%h exp=8000", rx_data2); end
        total++; if (rx_data !== 16'h0001) begin bad++; $display("FAIL order_msb_data got=%h exp=0001", rx_data); end
        total++; if (rx_valid2 !== 1'b0) begin bad++; $display("FAIL order_lsb_valid got=%b exp=0", rx_valid2); end
        total++; if (overflow2 !== 1'b0) begin bad++; $display("FAIL order_lsb_ovf got=%b exp=0", overflow2); end
        total++; if (busy2 !== 1'b0) begin bad++; $display("FAIL order_lsb_busy got=%b exp=0", busy2); end
    endtask

    task automatic test_overflow();
        rx_ready = 1'b0;
        frame(16'h1234);
        total++; if (rx_valid !== 1'b1) begin bad++; $display("FAIL ovf_first_valid got=%b exp=1", rx_valid); end
        total++; if (rx_data !== 16'h1234) begin bad++; $display("FAIL ovf_first_data got=%h exp=1234", rx_data); end
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL ovf_not_yet got=%b exp=0", overflow); end
        frame(16'h5678);
        total++; if (rx_data !== 16'h1234) begin bad++; $display("FAIL ovf_kept_data got=%h exp=1234", rx_data); end
        total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_set got=%b exp=1", overflow); end
        rx_ready = 1'b1;
        tick(1);
        rx_ready = 1'b0;
        total++; if (rx_valid !== 1'b0) begin bad++; $display("FAIL ovf_accept got=%b exp=0", rx_valid); end
        total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_sticky got=%b exp=1", overflow); end
        ovf_clr = 1'b1;
        tick(1);
        ovf_clr = 1'b0;
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL ovf_clear got=%b exp=0", overflow); end
    endtask

    task automatic test_back_to_back();
        rx_ready = 1'b0;
        frame(16'h00FF);
        total++; if (rx_data !== 16'h00FF) begin bad++; $display("FAIL b2b_first_data got=%h exp=00ff", rx_data); end
        cs_n = 1'b0;
        tick(PH);
        shift_bits(16'hFF00, W - 1);
        mosi = 1'b0;
        tick(PH);
        sclk = 1'b1;
        tick(SS + 1);
        rx_ready = 1'b1;
        tick(1);
        rx_ready = 1'b0;
        total++; if (rx_valid !== 1'b1) begin bad++; $display("FAIL b2b_valid got=%b exp=1", rx_valid); end
        total++; if (rx_data !== 16'hFF00) begin bad++; $display("FAIL b2b_data got=%h exp=ff00", rx_data); end
        tick(2);
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL b2b_ovf got=%b exp=0", overflow); end
        tick(PH);
        sclk = 1'b0;
        tick(PH);
        cs_n = 1'b1;
        tick(PH);
        rx_ready = 1'b1;
        tick(1);
        rx_ready = 1'b0;
    endtask

    task automatic test_abort();
        rx_ready = 1'b0;
        cs_n = 1'b0;
        tick(PH);
        shift_bits(16'hDEAD, 7);
        tick(PH);
        cs_n = 1'b1;
        tick(PH * 4);
        total++; if (rx_valid !== 1'b0) begin bad++; $display("FAIL abort_partial got=%b exp=0", rx_valid); end
        frame(16'hBEEF);
        total++; if (rx_valid !== 1'b1) begin bad++; $display("FAIL abort_valid got=%b exp=1", rx_valid); end
        total++; if (rx_data !== 16'hBEEF) begin bad++; $display("FAIL abort_data got=%h exp=beef", rx_data); end
    endtask

    task automatic test_async_reset();
        rx_ready = 1'b0;
        cs_n = 1'b0;
        tick(PH);
        shift_bits(16'h3C3C, 9);
        mosi = 1'b1;
        tick(3);
        #2;
        rst = 1'b0;
        #1;
        total++; if (rx_valid !== 1'b0) begin bad++; $display("FAIL arst_valid got=%b exp=0", rx_valid); end
        total++; if (rx_data !== 16'h0000) begin bad++; $display("FAIL arst_data got=%h exp=0000", rx_data); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL arst_busy got=%b exp=0", busy); end
        sclk = 1'b0;
        cs_n = 1'b1;
        mosi = 1'b0;
        tick(2);
        rst = 1'b1;
        tick(PH);
        frame(16'h0F0F);
        total++; if (rx_valid !== 1'b1) begin bad++; $display("FAIL arst_after_valid got=%b exp=1", rx_valid); end
        total++; if (rx_data !== 16'h0F0F) begin bad++; $display("FAIL arst_after_data got=%h exp=0f0f", rx_data); end
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL arst_after_ovf got=%b exp=0", overflow); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_bit_order();
        test_overflow();
        test_back_to_back();
        test_abort();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

endmodule
